ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter: takes the current `pc` and returns `inst` to decode/control/ALU.
- Fetches from instruction memory over a req/ack handshake and holds `inst` stable.
- Tells the core to stall while fetching, and flags misaligned fetch addresses and bus errors so the PC logic can redirect to the exception address.

Parameters:
- NOP_INST, 32'h0000_0000, value driven on `inst` whenever `inst_valid`=0.
- LINE_WORDS, 4, words per line buffer entry; used only with IFETCH_LINE_BUF_EN; power of two, minimum 2.

Ports:
- clk_cpu  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  fetch address from the program counter.
- inst  out  32  fetched instruction; NOP_INST when not valid.
- inst_valid  out  1  `inst` corresponds to the current `pc`.
- stall  out  1  combinational; equals !inst_valid && !misalign_excp && !fetch_err.
- misalign_excp  out  1  `pc[1:0]` != 0.
- fetch_err  out  1  memory returned an error for the current `pc`.
- imem_req  out  1  memory request.
- imem_addr  out  32  word-aligned request address.
- imem_rdata  in  32  read data; valid when `imem_ack`=1.
- imem_ack  in  1  request completes this cycle.
- imem_err  in  1  qualifies `imem_ack`: error response.
- line_inv  in  1  invalidate the line buffer; ignored when the feature is disabled.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; `cur_addr_valid`=0.
  - `inst`=NOP_INST; `inst_valid`, `misalign_excp`, `fetch_err`, `imem_req` = 0; `imem_addr`=0.
- States: IDLE, REQ, HOLD.
- A mismatch exists when !cur_addr_valid or `pc` != `cur_addr`.
- IDLE or HOLD with a mismatch:
  - Latch `cur_addr`<=pc and set `cur_addr_valid`.
  - Clear `inst_valid`, `misalign_excp` and `fetch_err`; `inst`<=NOP_INST.
  - If `pc[1:0]`!=0: set `misalign_excp`, stay HOLD, issue no request.
  - Otherwise: `imem_req`<=1, `imem_addr`<=pc, go to REQ.
- REQ:
  - `imem_req` and `imem_addr` stay constant until `imem_ack`. A request is never withdrawn.
  - On `imem_ack` with !imem_err: `inst`<=imem_rdata, `inst_valid`<=1, `imem_req`<=0, go to HOLD.
  - On `imem_ack` with imem_err: `fetch_err`<=1, `inst_valid` stays 0, `imem_req`<=0, go to HOLD.
  - If `pc` != `cur_addr` in the ack cycle: discard the response entirely (no valid, no error), go to IDLE; the new fetch issues the next cycle.
- HOLD with no mismatch: all outputs hold. `fetch_err` and `misalign_excp` are sticky until `pc` changes.
- Latency (pc change sampled at edge N, zero-wait memory acking in the same cycle as the request):
  - `imem_req` high after edge N.
  - `inst_valid` high after edge N+1.
  - 2 cycles in total; each memory wait cycle adds one cycle.
- Back-to-back fetches of the same `pc` hit in HOLD and cause no request.
- Reset asserted mid-REQ: drop `imem_req` immediately. The memory is reset by the same signal, so no ack is pending.

Optional Feature:
- Macro IFETCH_LINE_BUF_EN.
- When defined:
  - One LINE_WORDS-word line buffer with a tag (`pc[31:log2(LINE_WORDS)+2]`) and a valid bit.
  - Mismatch with a tag hit: `inst`<=buffer word and `inst_valid`<=1 at the next edge, with no memory request (1-cycle latency).
  - Miss: REQ performs LINE_WORDS sequential single-word requests from the line base, `imem_addr` incrementing by 4 after each ack.
  - `inst_valid` asserts when the word for `cur_addr` is written, not at line end; the remaining beats still complete.
  - Any error beat leaves the line invalid.
  - `line_inv` or reset clears the valid bit; `line_inv` during a fill also cancels validation at fill end.
- When undefined: no buffer, single-word fetch exactly as described above; `line_inv` is unused.

Decomposition:
- Put the `WORD` width macro, the state encoding (IDLE/REQ/HOLD) and the NOP_INST default in the shared src/defines.v.
- One natural sub-module: ifetch_line_buf, covering tag/data storage, hit compare, fill index and invalidate. It is instantiated only under IFETCH_LINE_BUF_EN.

Test Plan:
- Reset, then pc=0x0, memory acks in the same cycle with rdata 0x20010005 → imem_req=1 after edge 1; inst=0x20010005 and inst_valid=1 after edge 2; stall=0.
- pc held at 0x4 for 5 cycles after a fetch → exactly one imem_req pulse; inst stays stable.
- pc=0x8, memory waits 3 cycles → imem_addr stays 0x8 and stall=1 throughout; inst_valid=1 one cycle after the ack.
- pc changes 0x8→0x100 while a request is outstanding → the 0x8 data is discarded, then a request to 0x100 is issued and that data is returned.
- pc=0x6 → misalign_excp=1, no imem_req, inst=NOP_INST. Then ack with imem_err for pc=0x10 → fetch_err=1 and inst_valid=0 until pc changes.
- IFETCH_LINE_BUF_EN: pc=0x20 miss → 4 beats at 0x20/24/28/2C. Then pc=0x24 → inst_valid after 1 edge, no request. Then `line_inv` with pc=0x28 → a new fill.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: data width, FSM states, NOP default.
package ifetch_unit_pkg;

    localparam int unsigned     WORD             = 32;
    localparam logic [WORD-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_line_buf.sv
// Single-line instruction buffer: tag/data storage, hit compare, fill sequencing, invalidate.
// Instantiated by ifetch_unit only when IFETCH_LINE_BUF_EN is defined.
module ifetch_line_buf
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic            line_inv,
    input  logic [WORD-1:0] lookup_addr,
    output logic            hit,
    output logic [WORD-1:0] hit_word,
    input  logic            fill_start,
    input  logic            beat_we,
    input  logic            beat_err,
    input  logic [WORD-1:0] beat_data,
    output logic            fill_last
);

    localparam int unsigned IDX_W   = $clog2(LINE_WORDS);
    localparam int unsigned TAG_LSB = IDX_W + 2;

    logic [WORD-1:0]       data_q [LINE_WORDS];
    logic [WORD-1:0]       data_d [LINE_WORDS];
    logic [WORD-1:TAG_LSB] tag_q, tag_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  poison_q, poison_d;
    logic                  unused_lsbs;

    assign hit         = valid_q && (lookup_addr[WORD-1:TAG_LSB] == tag_q);
    assign hit_word    = data_q[lookup_addr[TAG_LSB-1:2]];
    assign fill_last   = (idx_q == IDX_W'(LINE_WORDS - 1));
    assign unused_lsbs = ^lookup_addr[1:0];

    // poison remembers an error beat or an invalidate seen mid-fill, so the line never validates
    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        poison_d = poison_q;
        if (fill_start) begin
            tag_d    = lookup_addr[WORD-1:TAG_LSB];
            idx_d    = '0;
            valid_d  = 1'b0;
            poison_d = 1'b0;
        end
        if (beat_we) begin
            data_d[idx_q] = beat_data;
            idx_d         = idx_q + 1'b1;
            if (fill_last) begin
                valid_d = !(poison_q || beat_err);
            end else if (beat_err) begin
                poison_d = 1'b1;
            end
        end
        if (line_inv) begin
            valid_d  = 1'b0;
            poison_d = 1'b1;
        end
    end

    always_ff @(posedge clk_cpu) begin
        data_q <= data_d;
        if (reset) begin
            tag_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            poison_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            poison_q <= poison_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: returns inst for pc over a req/ack memory handshake.
// Optional macro IFETCH_LINE_BUF_EN adds a single-line buffer (ifetch_line_buf).
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [WORD-1:0] NOP_INST   = NOP_INST_DEFAULT,
    parameter int unsigned     LINE_WORDS = 4
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic [WORD-1:0] pc,
    output logic [WORD-1:0] inst,
    output logic            inst_valid,
    output logic            stall,
    output logic            misalign_excp,
    output logic            fetch_err,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            imem_ack,
    input  logic            imem_err,
    input  logic            line_inv
);

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] cur_addr_q, cur_addr_d;
    logic            cur_valid_q, cur_valid_d;
    logic [WORD-1:0] inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            misalign_q, misalign_d;
    logic            fetch_err_q, fetch_err_d;
    logic            imem_req_q, imem_req_d;
    logic [WORD-1:0] imem_addr_q, imem_addr_d;
    logic            mismatch;

    assign mismatch = !cur_valid_q || (pc != cur_addr_q);

`ifdef IFETCH_LINE_BUF_EN
    localparam int unsigned TAG_LSB = $clog2(LINE_WORDS) + 2;

    logic            lb_hit, lb_fill_start, lb_beat_we, lb_fill_last;
    logic [WORD-1:0] lb_word;

    assign lb_beat_we = (state_q == REQ) && imem_ack;

    ifetch_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
        .clk_cpu     (clk_cpu),
        .reset       (reset),
        .line_inv    (line_inv),
        .lookup_addr (pc),
        .hit         (lb_hit),
        .hit_word    (lb_word),
        .fill_start  (lb_fill_start),
        .beat_we     (lb_beat_we),
        .beat_err    (imem_err),
        .beat_data   (imem_rdata),
        .fill_last   (lb_fill_last)
    );
`else
    logic unused_line_cfg;
    assign unused_line_cfg = line_inv ^ (LINE_WORDS == 0);
`endif

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        cur_valid_d  = cur_valid_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        fetch_err_d  = fetch_err_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
`ifdef IFETCH_LINE_BUF_EN
        lb_fill_start = 1'b0;
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (mismatch) begin
                    cur_addr_d   = pc;
                    cur_valid_d  = 1'b1;
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b0;
                    misalign_d   = 1'b0;
                    fetch_err_d  = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HOLD;
`ifdef IFETCH_LINE_BUF_EN
                    end else if (lb_hit) begin
                        inst_d       = lb_word;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        lb_fill_start = 1'b1;
                        imem_req_d    = 1'b1;
                        imem_addr_d   = {pc[WORD-1:TAG_LSB], {TAG_LSB{1'b0}}};
                        state_d       = REQ;
                    end
`else
                    end else begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc;
                        state_d     = REQ;
                    end
`endif
                end
            end
            REQ: begin
`ifdef IFETCH_LINE_BUF_EN
                // The fill always runs to the end of the line; pc moving mid-fill only drops the result
                if (mismatch) begin
                    cur_valid_d  = 1'b0;
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b0;
                    fetch_err_d  = 1'b0;
                end
                if (imem_ack) begin
                    if (!mismatch && (imem_addr_q == cur_addr_q)) begin
                        if (imem_err) begin
                            fetch_err_d = 1'b1;
                        end else begin
                            inst_d       = imem_rdata;
                            inst_valid_d = 1'b1;
                        end
                    end
                    if (lb_fill_last) begin
                        imem_req_d = 1'b0;
                        state_d    = mismatch ? IDLE : HOLD;
                    end else begin
                        imem_addr_d = imem_addr_q + 32'd4;
                    end
                end
`else
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    if (mismatch) begin
                        cur_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        if (imem_err) begin
                            fetch_err_d = 1'b1;
                        end else begin
                            inst_d       = imem_rdata;
                            inst_valid_d = 1'b1;
                        end
                        state_d = HOLD;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            cur_valid_q  <= 1'b0;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            cur_valid_q  <= cur_valid_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
            fetch_err_q  <= fetch_err_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
        end
    end

    assign inst          = inst_q;
    assign inst_valid    = inst_valid_q;
    assign misalign_excp = misalign_q;
    assign fetch_err     = fetch_err_q;
    assign imem_req      = imem_req_q;
    assign imem_addr     = imem_addr_q;
    assign stall         = !inst_valid_q && !misalign_q && !fetch_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: the bench plays instruction memory with programmable wait/error.
module tb_ifetch_unit;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        misalign_excp;
    logic        fetch_err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_err;
    logic        line_inv;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned mem_wait = 0;
    int unsigned waited   = 0;
    int unsigned acks     = 0;
    logic        mem_err_flag = 1'b0;
    logic [31:0] ack_addrs[$];
    logic        pend;
    logic [31:0] pend_addr;

    logic [31:0] prev_a;
    logic        prev_v, prev_m, prev_e;
    logic        have_prev = 1'b0;

    typedef struct {
        logic [31:0] a;
        int unsigned w;
        logic        e;
        int unsigned cyc;
        logic        v;
        logic        m;
        logic        er;
        int unsigned reqs;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_cpu = ~clk_cpu;

    ifetch_unit #(.NOP_INST(32'h0000_0000), .LINE_WORDS(4)) dut (
        .clk_cpu       (clk_cpu),
        .reset         (reset),
        .pc            (pc),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .stall         (stall),
        .misalign_excp (misalign_excp),
        .fetch_err     (fetch_err),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .imem_err      (imem_err),
        .line_inv      (line_inv)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h2001, a[15:0] ^ 16'h0005};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive this cycle's memory response, then sample just after the edge.
    task automatic tick();
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        pend       = 1'b0;
        if (imem_req && !reset) begin
            if (waited >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_err   = mem_err_flag;
                imem_rdata = mem_word(imem_addr);
                ack_addrs.push_back(imem_addr);
                acks++;
                waited = 0;
            end else begin
                waited++;
                pend      = 1'b1;
                pend_addr = imem_addr;
            end
        end else begin
            waited = 0;
        end
        @(posedge clk_cpu);
        #1;
        if (inst_valid) check("inst_matches_pc", inst, mem_word(pc));
        else            check("nop_when_invalid", inst, 32'h0);
        check("stall_rule", {31'b0, stall}, {31'b0, !inst_valid && !misalign_excp && !fetch_err});
        if (pend) begin
            check("req_held", {31'b0, imem_req}, 32'd1);
            check("addr_held", imem_addr, pend_addr);
        end
    endtask

    task automatic do_fetch(input string name, input logic [31:0] a, input int unsigned w,
                            input logic e, input int unsigned exp_cyc, input logic exp_v,
                            input logic exp_m, input logic exp_er, input int unsigned exp_reqs);
        int unsigned a0  = acks;
        int unsigned cyc = 0;
        logic        done = 1'b0;
        pc           = a;
        mem_wait     = w;
        mem_err_flag = e;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
            done = inst_valid || misalign_excp || fetch_err;
        end
        check({name, "_cycles"}, cyc, exp_cyc);
        check({name, "_valid"}, {31'b0, inst_valid}, {31'b0, exp_v});
        check({name, "_inst"}, inst, exp_v ? mem_word(a) : 32'h0);
        check({name, "_misalign"}, {31'b0, misalign_excp}, {31'b0, exp_m});
        check({name, "_err"}, {31'b0, fetch_err}, {31'b0, exp_er});
        check({name, "_reqs"}, acks - a0, exp_reqs);
        if (exp_reqs == 1 && ack_addrs.size() > 0)
            check({name, "_addr"}, ack_addrs[ack_addrs.size()-1], a);
    endtask

    // Reference: same pc repeats the last result for free; misaligned pcs never reach memory;
    // a new aligned pc costs 2 cycles plus memory waits and yields data or an error.
    task automatic model_fetch(input logic [31:0] a, input int unsigned w, input logic e);
        int unsigned cyc, reqs;
        logic        v, m, er;
        if (have_prev && a == prev_a) begin
            cyc = 1; reqs = 0; v = prev_v; m = prev_m; er = prev_e;
        end else if (a[1:0] != 2'b00) begin
            cyc = 1; reqs = 0; v = 1'b0; m = 1'b1; er = 1'b0;
        end else begin
            cyc = 2 + w; reqs = 1; v = !e; m = 1'b0; er = e;
        end
        do_fetch("rand", a, w, e, cyc, v, m, er, reqs);
        prev_a = a; prev_v = v; prev_m = m; prev_e = er; have_prev = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pc       = 32'h0;
        line_inv = 1'b0;
        mem_wait = 0;
        tick();
        tick();
        check("rst_inst", inst, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign_excp}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned a0;
        int unsigned n;
        logic [31:0] held;
        logic [31:0] ra;
        int unsigned r;

        reset = 1'b1; pc = 32'h0; line_inv = 1'b0;
        imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = 32'h0;
        do_reset();

`ifndef IFETCH_LINE_BUF_EN
        // First fetch after reset: request after one edge, data after two.
        tick();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_not_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("first_valid", {31'b0, inst_valid}, 32'd1);
        check("first_inst", inst, 32'h2001_0005);
        check("first_stall", {31'b0, stall}, 32'd0);
        check("first_req_drop", {31'b0, imem_req}, 32'd0);

        // Holding pc costs no further requests and inst stays put.
        do_fetch("hold4", 32'h4, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1);
        a0 = acks;
        held = inst;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_inst_stable", inst, held);
        end
        check("hold_no_reqs", acks - a0, 0);

        vecs.push_back('{32'h0000_0008, 3, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h0000_0006, 0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{32'h0000_0006, 0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{32'h0000_0010, 0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{32'h0000_0010, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{32'h0000_0014, 1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hFFFF_FFFC, 2, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{32'hFFFF_FFFC, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{32'h0000_0003, 0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{32'h0000_0000, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1});
        foreach (vecs[i])
            do_fetch($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].e,
                     vecs[i].cyc, vecs[i].v, vecs[i].m, vecs[i].er, vecs[i].reqs);

        // pc moves while a request is outstanding: stale data dropped, new address fetched.
        a0 = acks;
        pc = 32'h8; mem_wait = 3; mem_err_flag = 1'b0;
        tick();
        tick();
        check("disc_req_out", {31'b0, imem_req}, 32'd1);
        check("disc_addr_out", imem_addr, 32'h8);
        pc = 32'h100; mem_wait = 0;
        tick();
        check("disc_no_valid", {31'b0, inst_valid}, 32'd0);
        check("disc_no_err", {31'b0, fetch_err}, 32'd0);
        n = 0;
        while (!inst_valid && n < 10) begin
            tick();
            n++;
        end
        check("disc_new_inst", inst, mem_word(32'h100));
        check("disc_reqs", acks - a0, 2);
        check("disc_old_addr", ack_addrs[ack_addrs.size()-2], 32'h8);
        check("disc_new_addr", ack_addrs[ack_addrs.size()-1], 32'h100);

        // Reset in the middle of a request drops it.
        pc = 32'h40; mem_wait = 5;
        tick();
        tick();
        check("midreq_req", {31'b0, imem_req}, 32'd1);
        reset = 1'b1;
        tick();
        check("midreq_rst_req", {31'b0, imem_req}, 32'd0);
        check("midreq_rst_addr", imem_addr, 32'h0);
        check("midreq_rst_valid", {31'b0, inst_valid}, 32'd0);
        reset = 1'b0;
        do_fetch("after_rst", 32'h40, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1);

        model_fetch(32'h200, 0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      ra = prev_a;
            else if (r < 4) ra = ($urandom & 32'h0000_03FC) | 32'($urandom_range(1, 3));
            else            ra = $urandom & 32'h0000_03FC;
            model_fetch(ra, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end
`else
        // Line fill on a miss, buffer hit on a neighbour, refill after invalidate.
        ack_addrs.delete();
        pc = 32'h20; mem_wait = 0; mem_err_flag = 1'b0;
        tick();
        tick();
        check("lb_first_valid", {31'b0, inst_valid}, 32'd1);
        check("lb_first_inst", inst, mem_word(32'h20));
        n = 0;
        while (acks < 4 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check("lb_fill_beats", acks, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("lb_beat%0d_addr", i), ack_addrs[i], 32'h20 + 32'(4 * i));
        check("lb_req_done", {31'b0, imem_req}, 32'd0);
        pc = 32'h24;
        tick();
        check("lb_hit_valid", {31'b0, inst_valid}, 32'd1);
        check("lb_hit_inst", inst, mem_word(32'h24));
        check("lb_hit_noreq", {31'b0, imem_req}, 32'd0);
        check("lb_hit_acks", acks, 4);
        line_inv = 1'b1;
        tick();
        line_inv = 1'b0;
        pc = 32'h28;
        tick();
        check("lb_inv_miss_req", {31'b0, imem_req}, 32'd1);
        n = 0;
        while (acks < 8 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check("lb_refill_beats", acks, 8);
        check("lb_refill_base", ack_addrs[4], 32'h20);
        check("lb_refill_inst", inst, mem_word(32'h28));
        check("lb_refill_valid", {31'b0, inst_valid}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
